pwm_encoder_mixer: RTL and testbench

PWM_ENCODER_MIXER -- requirements
Module: pwm_encoder_mixer

---
 rtl/pwm_encoder_mixer.sv | 111 +++++++++++
 tb/tb_pwm_encoder_mixer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_encoder_mixer.sv
// Quadrature-encoder driven PWM mixer: each channel debounces an A/B encoder pair,
// steps its duty level per detent and drives a PWM output from one shared counter.
module pwm_encoder_mixer #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 8,
   parameter int DEBOUNCE = 8,
   parameter int SATURATE = 1,
   parameter int STEP     = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       enc_a,
   input  logic [CHANNELS-1:0]       enc_b,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic [CHANNELS*WIDTH-1:0] level,
   output logic                      period_start
);

   localparam logic [WIDTH-1:0] LEVEL_MAX = '1;
   localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] counter;
   logic             load_duty;

   // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
      end else begin
         counter <= counter + WIDTH'(1);
      end
   end

   assign period_start = (counter == '0);
   assign load_duty    = (counter == LEVEL_MAX);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic                samp_a, samp_b;
      logic [DEBOUNCE-1:0] sh_a, sh_b;
      logic                deb_a, deb_b;
      logic                prev_a, prev_b;
      logic                a_rise, a_fall, b_move;
      logic                inc, dec;
      logic [WIDTH:0]      sum, diff;
      logic [WIDTH-1:0]    level_q, level_d, duty_active;

      // The capture flop is the first sample of the asynchronous pin; the window
      // then requires DEBOUNCE identical samples before the debounced phase moves.
      always_ff @(posedge clk) begin
         if (reset) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
            sh_a   <= '0;
            sh_b   <= '0;
            deb_a  <= 1'b0;
            deb_b  <= 1'b0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
         end else begin
            samp_a <= enc_a[i];
            samp_b <= enc_b[i];
            sh_a   <= {sh_a[DEBOUNCE-2:0], samp_a};
            sh_b   <= {sh_b[DEBOUNCE-2:0], samp_b};
            if (&sh_a)       deb_a <= 1'b1;
            else if (~|sh_a) deb_a <= 1'b0;
            if (&sh_b)       deb_b <= 1'b1;
            else if (~|sh_b) deb_b <= 1'b0;
            prev_a <= deb_a;
            prev_b <= deb_b;
         end
      end

      assign a_rise = deb_a & ~prev_a;
      assign a_fall = ~deb_a & prev_a;
      assign b_move = deb_b ^ prev_b;

      // A edges count only while B is steady; simultaneous A/B moves are ignored.
      assign inc = ~b_move & ((a_rise & ~deb_b) | (a_fall & deb_b));
      assign dec = ~b_move & ((a_fall & ~deb_b) | (a_rise & deb_b));

      assign sum  = {1'b0, level_q} + STEP_EXT;
      assign diff = {1'b0, level_q} - STEP_EXT;

      // NOTE: level_d gets its default first, so no path through this block can infer a latch.
      always_comb begin
         level_d = level_q;
         if (inc) begin
            if (SATURATE != 0 && sum[WIDTH]) level_d = LEVEL_MAX;
            else                             level_d = sum[WIDTH-1:0];
         end else if (dec) begin
            if (SATURATE != 0 && diff[WIDTH]) level_d = '0;
            else                              level_d = diff[WIDTH-1:0];
         end
      end

      // The shadow only reloads at the last count, so a period is never cut short.
      always_ff @(posedge clk) begin
         if (reset) begin
            level_q     <= '0;
            duty_active <= '0;
         end else begin
            level_q <= level_d;
            if (load_duty) duty_active <= level_q;
         end
      end

      assign pwm_out[i]                = (counter < duty_active);
      assign level[i*WIDTH +: WIDTH]   = level_q;
   end

endmodule

// File: tb/tb_pwm_encoder_mixer.sv
// Directed bench for pwm_encoder_mixer: stimulus pushes expected level changes,
// a negedge monitor pops and compares them whenever a level output moves.
`timescale 1ns/1ps
module tb_pwm_encoder_mixer;
   localparam int CH     = 3;
   localparam int W      = 8;
   localparam int DEB    = 8;
   localparam int PERIOD = 256;
   // Driven at negedge N: first sample edge N+1, level moves at edge N+1+DEB+2.
   localparam int LAT    = DEB + 3;
   localparam int SETTLE = LAT + 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [CH-1:0]   enc_a = '0;
   logic [CH-1:0]   enc_b = '0;
   logic [CH-1:0]   pwm_out;
   logic [CH*W-1:0] level;
   logic            period_start;
   logic            wa = 1'b0;
   logic            wb = 1'b0;
   logic            w_pwm;
   logic [W-1:0]    w_level;
   logic            w_ps;

   always #5 clk = ~clk;

   pwm_encoder_mixer #(.CHANNELS(CH), .WIDTH(W), .DEBOUNCE(DEB), .SATURATE(1), .STEP(1)) u_dut (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .pwm_out(pwm_out), .level(level), .period_start(period_start));

   pwm_encoder_mixer #(.CHANNELS(1), .WIDTH(W), .DEBOUNCE(DEB), .SATURATE(0), .STEP(1)) u_wrap (
      .clk(clk), .reset(reset), .enc_a(wa), .enc_b(wb),
      .pwm_out(w_pwm), .level(w_level), .period_start(w_ps));

   typedef struct {
      int ch;
      int value;
      int cycle;
   } exp_t;

   exp_t            sb_q[$];
   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              exp_lv[CH];
   logic            mon_en = 1'b0;
   logic [CH*W-1:0] last_level = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every level movement must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < CH; c++) begin
            if (level[c*W +: W] !== last_level[c*W +: W]) begin
               if (sb_q.size() == 0) begin
                  check($sformatf("unexpected_change_ch%0d", c), 32'(level[c*W +: W]),
                        32'(last_level[c*W +: W]));
               end else begin
                  check($sformatf("sb_channel_ch%0d", c), c, sb_q[0].ch);
                  check($sformatf("sb_value_ch%0d", c), 32'(level[c*W +: W]), sb_q[0].value);
                  check($sformatf("sb_time_ch%0d", c), cyc, sb_q[0].cycle);
                  void'(sb_q.pop_front());
               end
            end
         end
      end
      last_level <= level;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: no completion after 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   function automatic int step_level(input int lv, input logic up);
      if (up) return (lv >= 255) ? 255 : lv + 1;
      return (lv <= 0) ? 0 : lv - 1;
   endfunction

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Flip B first where needed so the following A toggle counts in direction up.
   task automatic prep(input logic [CH-1:0] mask, input logic up);
      logic moved;
      moved = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (mask[c] && enc_a[c] == (up ? ~enc_b[c] : enc_b[c])) begin
            enc_b[c] = ~enc_b[c];
            moved    = 1'b1;
         end
      end
      if (moved) wait_neg(SETTLE);
   endtask

   task automatic fire(input logic [CH-1:0] mask, input logic up);
      int nv;
      for (int c = 0; c < CH; c++) begin
         if (mask[c]) begin
            enc_a[c] = up ? ~enc_b[c] : enc_b[c];
            nv = step_level(exp_lv[c], up);
            if (nv != exp_lv[c]) sb_q.push_back('{c, nv, cyc + LAT});
            exp_lv[c] = nv;
         end
      end
   endtask

   task automatic detent(input logic [CH-1:0] mask, input logic up, input int n);
      repeat (n) begin
         prep(mask, up);
         fire(mask, up);
         wait_neg(SETTLE);
      end
   endtask

   task automatic wait_ps(input string name);
      int n;
      n = 0;
      while (!period_start && n < 2*PERIOD) begin
         @(negedge clk);
         n++;
      end
      if (!period_start) check(name, 32'(period_start), 1);
   endtask

   task automatic measure(input int ch, input int duty, input string name);
      int hi, mism;
      hi = 0;
      mism = 0;
      wait_ps({name, "_timeout"});
      for (int k = 0; k < PERIOD; k++) begin
         if (k > 0) @(negedge clk);
         hi += int'(pwm_out[ch]);
         if (pwm_out[ch] !== (k < duty)) mism++;
      end
      check({name, "_high"}, hi, duty);
      check({name, "_shape"}, mism, 0);
   endtask

   initial begin : main
      int ps, pw, first, second, hi1, hi2, mism;
      for (int c = 0; c < CH; c++) exp_lv[c] = 0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_level", 32'(level), 0);
      check("reset_pwm", 32'(pwm_out), 0);
      check("reset_period_start", 32'(period_start), 1);
      check("reset_wrap_level", 32'(w_level), 0);
      mon_en = 1'b1;

      // Idle for two periods with inputs low.
      ps = 0; pw = 0; first = -1; second = -1;
      for (int k = 0; k < 2*PERIOD; k++) begin
         if (k > 0) @(negedge clk);
         if (period_start) begin
            ps++;
            if (first < 0) first = k;
            else if (second < 0) second = k;
         end
         if (pwm_out != '0) pw++;
      end
      check("idle_period_starts", ps, 2);
      check("idle_pwm_high", pw, 0);
      check("idle_period_gap", second - first, PERIOD);

      // Single clean detent on ch0.
      @(negedge clk);
      detent(3'b001, 1'b1, 1);
      check("ch1_ch2_quiet", 32'(level[W +: 2*W]), 0);
      measure(0, 1, "ch0_duty1");

      // Chatter on ch1 A, three-cycle pulses, ending low.
      for (int t = 0; t < 10; t++) begin
         enc_a[1] = ~enc_a[1];
         wait_neg(3);
      end
      wait_neg(SETTLE + 2);
      check("chatter_ch1", 32'(level[W +: W]), 0);

      // B-only move, then A and B together on ch2.
      enc_b[2] = 1'b1;
      wait_neg(SETTLE);
      enc_a[2] = 1'b1;
      enc_b[2] = 1'b0;
      wait_neg(SETTLE);
      check("illegal_ch2", 32'(level[2*W +: W]), 0);

      // Simultaneous detents on ch1 and ch2, then ch2 up to 64.
      detent(3'b110, 1'b1, 1);
      detent(3'b100, 1'b1, 63);
      check("ch2_at_64", 32'(level[2*W +: W]), 64);

      // Step ch2 to 65 while the counter reads 100.
      prep(3'b100, 1'b1);
      wait_ps("midperiod_timeout");
      hi1 = 0; hi2 = 0; mism = 0;
      for (int k = 0; k < 2*PERIOD; k++) begin
         if (k > 0) @(negedge clk);
         if (k < PERIOD) hi1 += int'(pwm_out[2]);
         else            hi2 += int'(pwm_out[2]);
         if (pwm_out[2] !== ((k % PERIOD) < ((k < PERIOD) ? 64 : 65))) mism++;
         if (k == 89) fire(3'b100, 1'b1);
      end
      check("midperiod_old_duty", hi1, 64);
      check("midperiod_new_duty", hi2, 65);
      check("midperiod_shape", mism, 0);
      wait_neg(1);

      // Saturation at both ends.
      detent(3'b100, 1'b1, 190);
      check("ch2_at_255", 32'(level[2*W +: W]), 255);
      detent(3'b100, 1'b1, 1);
      check("ch2_sat_high", 32'(level[2*W +: W]), 255);
      measure(2, 255, "ch2_full");
      detent(3'b010, 1'b0, 2);
      check("ch1_sat_low", 32'(level[W +: W]), 0);

      // Wrapping instance: decrement from 0, then increment back.
      wb = 1'b1;
      wait_neg(SETTLE);
      wa = 1'b1;
      wait_neg(SETTLE);
      check("wrap_dec", 32'(w_level), 255);
      wa = 1'b0;
      wait_neg(SETTLE);
      check("wrap_inc", 32'(w_level), 0);

      // Reset mid-operation with a half-filled debounce window on ch1.
      enc_a[1] = ~enc_a[1];
      wait_neg(5);
      reset = 1'b1;
      enc_a = '0;
      enc_b = '0;
      wb = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (exp_lv[c] != 0) sb_q.push_back('{c, 0, cyc + 1});
         exp_lv[c] = 0;
      end
      wait_neg(2);
      reset = 1'b0;
      wait_neg(SETTLE + 4);
      check("after_reset_levels", 32'(level), 0);

      // Build levels {10, 20, 30}.
      detent(3'b111, 1'b1, 10);
      detent(3'b110, 1'b1, 10);
      detent(3'b100, 1'b1, 10);
      check("levels_10_20_30", 32'(level), 32'({8'd30, 8'd20, 8'd10}));

      // Reset at counter 77 while ch0 A is held high through reset.
      wait_ps("reset77_timeout");
      wait_neg(77);
      reset = 1'b1;
      enc_a = 3'b001;
      enc_b = '0;
      for (int c = 0; c < CH; c++) begin
         sb_q.push_back('{c, 0, cyc + 1});
         exp_lv[c] = 0;
      end
      @(negedge clk);
      check("reset77_period_start", 32'(period_start), 1);
      check("reset77_pwm", 32'(pwm_out), 0);
      check("reset77_level", 32'(level), 0);
      wait_neg(2);
      reset = 1'b0;
      sb_q.push_back('{0, 1, cyc + LAT});
      exp_lv[0] = 1;
      wait_neg(SETTLE);
      check("raw_high_after_reset", 32'(level[0 +: W]), 1);

      wait_neg(4);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
